spi_master_driver: RTL and testbench

SPI_MASTER_DRIVER -- requirements
Module: spi_master_driver

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_clk_div.sv | 33 +++
 rtl/spi_master_driver.sv | 171 +++++++++++++++++
 tb/tb_spi_master_driver.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state type, SPI mode constants and a counter-width helper.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        GAP   = 3'd4
    } state_t;

    // SPI mode 0: sclk idles low, data sampled on the rising sclk edge.
    localparam int unsigned CPOL = 0;
    localparam int unsigned CPHA = 0;

    // Bits needed to hold values 0..max_val; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period timer: tick is high during the last cycle of a SCLK_HALF-cycle phase.
// restart is asserted on the edge that enters a new phase.
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int unsigned SCLK_HALF = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int unsigned   CW   = cnt_width(SCLK_HALF);
    localparam logic [CW-1:0] LAST = CW'(SCLK_HALF - 1);

    logic [CW-1:0] cnt;

    // Count cycles within the phase; saturate at the last cycle so the counter never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (restart) begin
            cnt  <= '0;
            tick <= (LAST == '0);
        end else if (cnt != LAST) begin
            cnt  <= cnt + CW'(1);
            tick <= ((cnt + CW'(1)) == LAST);
        end
    end

endmodule

// File: rtl/spi_master_driver.sv
// SPI master (CPOL=0, CPHA=0), MSB first, one DATA_WIDTH-bit word per start.
// Optional feature: define SPI_MASTER_LOOPBACK_EN to sample the internal mosi
// instead of the miso pin.
module spi_master_driver
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned SCLK_HALF  = 1,
    parameter int unsigned CS_GAP     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  ready,
    output logic                  busy,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  sclk,
    output logic                  cs
);

    localparam int unsigned   BW       = cnt_width(DATA_WIDTH);
    localparam int unsigned   GW       = cnt_width(CS_GAP);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH);
    localparam logic [GW-1:0] GAP_LAST = (CS_GAP == 0) ? '0 : GW'(CS_GAP - 1);
    localparam logic          SCLK_IDLE = 1'(CPOL);

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] tx_sr, tx_next, tx_shift;
    logic [DATA_WIDTH-1:0] rx_sr, rx_next;
    logic [BW-1:0]         bit_cnt, bit_next;
    logic [GW-1:0]         gap_cnt, gap_next;
    logic [DATA_WIDTH-1:0] dout_next;
    logic                  ready_next, busy_next, mosi_next, sclk_next, cs_next;
    logic                  restart_c;
    logic                  tick;
    logic                  serial_in;

`ifdef SPI_MASTER_LOOPBACK_EN
    logic unused_miso;
    assign serial_in   = mosi;
    assign unused_miso = miso;
`else
    assign serial_in = miso;
`endif

    assign tx_shift = tx_sr << 1;

    // Phase timer shared by SETUP, HIGH and LOW.
    spi_clk_div #(
        .SCLK_HALF(SCLK_HALF)
    ) u_clk_div (
        .clk    (clk),
        .rst    (rst),
        .restart(restart_c),
        .tick   (tick)
    );

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tx_sr    <= '0;
            rx_sr    <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            data_out <= '0;
            ready    <= 1'b0;
            busy     <= 1'b0;
            mosi     <= 1'b0;
            sclk     <= SCLK_IDLE;
            cs       <= 1'b1;
        end else begin
            state    <= state_next;
            tx_sr    <= tx_next;
            rx_sr    <= rx_next;
            bit_cnt  <= bit_next;
            gap_cnt  <= gap_next;
            data_out <= dout_next;
            ready    <= ready_next;
            busy     <= busy_next;
            mosi     <= mosi_next;
            sclk     <= sclk_next;
            cs       <= cs_next;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_next = state;
        tx_next    = tx_sr;
        rx_next    = rx_sr;
        bit_next   = bit_cnt;
        gap_next   = gap_cnt;
        dout_next  = data_out;
        ready_next = 1'b0;
        busy_next  = busy;
        mosi_next  = mosi;
        sclk_next  = sclk;
        cs_next    = cs;
        restart_c  = 1'b0;

        case (state)
            IDLE: begin
                if (start && !busy) begin
                    state_next = SETUP;
                    restart_c  = 1'b1;
                    busy_next  = 1'b1;
                    cs_next    = 1'b0;
                    tx_next    = data_in;
                    mosi_next  = data_in[DATA_WIDTH-1];
                    rx_next    = '0;
                    bit_next   = '0;
                end
            end
            SETUP: begin
                if (tick) begin
                    state_next = HIGH;
                    restart_c  = 1'b1;
                    sclk_next  = ~SCLK_IDLE;
                    rx_next    = (rx_sr << 1) | DATA_WIDTH'(serial_in);
                    bit_next   = bit_cnt + BW'(1);
                end
            end
            HIGH: begin
                if (tick) begin
                    state_next = LOW;
                    restart_c  = 1'b1;
                    sclk_next  = SCLK_IDLE;
                    tx_next    = tx_shift;
                    mosi_next  = tx_shift[DATA_WIDTH-1];
                end
            end
            LOW: begin
                if (tick) begin
                    if (bit_cnt == BIT_LAST) begin
                        cs_next    = 1'b1;
                        mosi_next  = 1'b0;
                        dout_next  = rx_sr;
                        ready_next = 1'b1;
                        gap_next   = '0;
                        if (CS_GAP == 0) begin
                            state_next = IDLE;
                            busy_next  = 1'b0;
                        end else begin
                            state_next = GAP;
                        end
                    end else begin
                        state_next = HIGH;
                        restart_c  = 1'b1;
                        sclk_next  = ~SCLK_IDLE;
                        rx_next    = (rx_sr << 1) | DATA_WIDTH'(serial_in);
                        bit_next   = bit_cnt + BW'(1);
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                end else begin
                    gap_next = gap_cnt + GW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_master_driver.sv
// Self-checking bench: instance a uses default timing, instance b uses SCLK_HALF=3, CS_GAP=0.
// A behavioural SPI slave per instance records mosi at sclk rises and shifts out a word on miso.
module tb_spi_master_driver;

    localparam int unsigned DW     = 4;
    localparam int unsigned HALF_A = 1;
    localparam int unsigned GAP_A  = 2;
    localparam int unsigned HALF_B = 3;
    localparam int unsigned GAP_B  = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    logic          a_start = 1'b0, b_start = 1'b0;
    logic [DW-1:0] a_din = '0, b_din = '0;
    logic [DW-1:0] a_dout, b_dout;
    logic          a_ready, a_busy, a_mosi, a_sclk, a_cs;
    logic          b_ready, b_busy, b_mosi, b_sclk, b_cs;
    logic          a_miso = 1'b0, b_miso = 1'b0;

    spi_master_driver #(.DATA_WIDTH(DW), .SCLK_HALF(HALF_A), .CS_GAP(GAP_A)) u_dut_a (
        .clk(clk), .rst(rst), .start(a_start), .data_in(a_din), .data_out(a_dout),
        .ready(a_ready), .busy(a_busy), .mosi(a_mosi), .miso(a_miso), .sclk(a_sclk), .cs(a_cs));

    spi_master_driver #(.DATA_WIDTH(DW), .SCLK_HALF(HALF_B), .CS_GAP(GAP_B)) u_dut_b (
        .clk(clk), .rst(rst), .start(b_start), .data_in(b_din), .data_out(b_dout),
        .ready(b_ready), .busy(b_busy), .mosi(b_mosi), .miso(b_miso), .sclk(b_sclk), .cs(b_cs));

    // Expected received word: the slave's word, or the transmitted word in loopback builds.
    function automatic logic [DW-1:0] exp_rx(input logic [DW-1:0] d, input logic [DW-1:0] sw);
`ifdef SPI_MASTER_LOOPBACK_EN
        return d;
`else
        return sw;
`endif
    endfunction

    // Slave/monitor state for instance a.
    logic [DW-1:0] a_word = '0, a_cap = '0;
    int a_widx = 0, a_rises = 0, a_cs_low = 0, a_ready_n = 0, a_falls = 0;
    int a_rise_cyc = 0, a_bfall_cyc = 0;
    logic a_prev_sclk = 1'b0, a_prev_cs = 1'b1, a_prev_busy = 1'b0, a_ready_at_rise = 1'b0;
    logic [DW-1:0] a_capq[$];
    int a_lowq[$], a_riseq[$];

    // Slave/monitor state for instance b.
    logic [DW-1:0] b_word = '0, b_cap = '0;
    int b_widx = 0, b_rises = 0, b_cs_low = 0, b_ready_n = 0, b_falls = 0;
    int b_hi_run = 0, b_lo_run = 0, b_hi_min = 0, b_hi_max = 0, b_lo_min = 0, b_lo_max = 0;
    logic b_prev_sclk = 1'b0, b_prev_cs = 1'b1;
    logic [DW-1:0] b_capq[$], b_doutq[$];
    int b_lowq[$], b_riseq[$];

    // Instance a slave and bus monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (a_cs === 1'b0 && a_prev_cs === 1'b1) begin
            a_falls++;
            a_widx   = DW - 1;
            a_miso   = a_word[DW-1];
            a_cap    = '0;
            a_rises  = 0;
            a_cs_low = 0;
        end
        if (a_cs === 1'b0) a_cs_low++;
        if (a_sclk === 1'b1 && a_prev_sclk === 1'b0) begin
            a_cap = {a_cap[DW-2:0], a_mosi};
            a_rises++;
        end
        if (a_sclk === 1'b0 && a_prev_sclk === 1'b1 && a_widx > 0) begin
            a_widx--;
            a_miso = a_word[a_widx];
        end
        if (a_cs === 1'b1 && a_prev_cs === 1'b0) begin
            a_capq.push_back(a_cap);
            a_lowq.push_back(a_cs_low);
            a_riseq.push_back(a_rises);
            a_rise_cyc      = cyc;
            a_ready_at_rise = a_ready;
        end
        if (a_ready === 1'b1) a_ready_n++;
        if (a_busy === 1'b0 && a_prev_busy === 1'b1) a_bfall_cyc = cyc;
        a_prev_sclk = a_sclk;
        a_prev_cs   = a_cs;
        a_prev_busy = a_busy;
    end

    // Instance b slave and bus monitor, including sclk phase-length tracking.
    always @(negedge clk) begin
        if (b_cs === 1'b0 && b_prev_cs === 1'b1) begin
            b_falls++;
            b_widx   = DW - 1;
            b_miso   = b_word[DW-1];
            b_cap    = '0;
            b_rises  = 0;
            b_cs_low = 0;
            b_hi_run = 0;
            b_lo_run = 0;
            b_hi_min = 1000;
            b_hi_max = 0;
            b_lo_min = 1000;
            b_lo_max = 0;
        end
        if (b_cs === 1'b0) b_cs_low++;
        if (b_sclk === 1'b1) begin
            b_hi_run++;
        end else if (b_prev_sclk === 1'b1) begin
            if (b_hi_run < b_hi_min) b_hi_min = b_hi_run;
            if (b_hi_run > b_hi_max) b_hi_max = b_hi_run;
            b_hi_run = 0;
        end
        if (b_cs === 1'b0 && b_rises > 0 && b_sclk === 1'b0) b_lo_run++;
        if (b_sclk === 1'b1 && b_prev_sclk === 1'b0) begin
            if (b_lo_run > 0) begin
                if (b_lo_run < b_lo_min) b_lo_min = b_lo_run;
                if (b_lo_run > b_lo_max) b_lo_max = b_lo_run;
            end
            b_lo_run = 0;
            b_cap = {b_cap[DW-2:0], b_mosi};
            b_rises++;
        end
        if (b_sclk === 1'b0 && b_prev_sclk === 1'b1 && b_widx > 0) begin
            b_widx--;
            b_miso = b_word[b_widx];
        end
        if (b_cs === 1'b1 && b_prev_cs === 1'b0) begin
            b_capq.push_back(b_cap);
            b_lowq.push_back(b_cs_low);
            b_riseq.push_back(b_rises);
        end
        if (b_ready === 1'b1) begin
            b_ready_n++;
            b_doutq.push_back(b_dout);
        end
        b_prev_sclk = b_sclk;
        b_prev_cs   = b_cs;
    end

    // One transfer on instance a; data_in is scrambled right after acceptance.
    task automatic xfer_a(input logic [DW-1:0] d, input logic [DW-1:0] sw, output bit to);
        a_word = sw;
        @(negedge clk);
        a_din   = d;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        a_din   = DW'($urandom);
        to = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (a_busy === 1'b0) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    // One transfer on instance b; data_in is scrambled right after acceptance.
    task automatic xfer_b(input logic [DW-1:0] d, input logic [DW-1:0] sw, output bit to);
        b_word = sw;
        @(negedge clk);
        b_din   = d;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        b_din   = DW'($urandom);
        to = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (b_busy === 1'b0) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({a_cs, a_sclk, a_mosi, a_ready, a_busy} !== 5'b10000)
            $display("FAIL reset_a_ctrl: got %b expected 10000", {a_cs, a_sclk, a_mosi, a_ready, a_busy});
        else n_pass++;
        n_total++;
        if (a_dout !== 4'h0) $display("FAIL reset_a_dout: got %h expected 0", a_dout);
        else n_pass++;
        n_total++;
        if ({b_cs, b_sclk, b_mosi, b_ready, b_busy, b_dout} !== 9'b100000000)
            $display("FAIL reset_b: got %b expected 100000000", {b_cs, b_sclk, b_mosi, b_ready, b_busy, b_dout});
        else n_pass++;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_total++;
        if ({a_cs, a_busy} !== 2'b10) $display("FAIL idle_after_reset: got %b expected 10", {a_cs, a_busy});
        else n_pass++;
    endtask

    task automatic test_basic();
        bit to;
        int r0;
        logic [DW-1:0] cap;
        a_capq.delete(); a_lowq.delete(); a_riseq.delete();
        r0 = a_ready_n;
        xfer_a(4'hA, 4'h5, to);
        cap = (a_capq.size() > 0) ? a_capq[0] : 'x;
        n_total++;
        if (to !== 1'b0) $display("FAIL basic_timeout: busy never fell");
        else n_pass++;
        n_total++;
        if (cap !== 4'hA) $display("FAIL basic_mosi: got %h expected a", cap);
        else n_pass++;
        n_total++;
        if (a_lowq.size() != 1 || a_lowq[0] != int'(HALF_A * (2 * DW + 1)))
            $display("FAIL basic_cs_low: got %p expected %0d", a_lowq, HALF_A * (2 * DW + 1));
        else n_pass++;
        n_total++;
        if (a_riseq.size() != 1 || a_riseq[0] != DW)
            $display("FAIL basic_rises: got %p expected %0d", a_riseq, DW);
        else n_pass++;
        n_total++;
        if (a_dout !== exp_rx(4'hA, 4'h5)) $display("FAIL basic_dout: got %h expected %h", a_dout, exp_rx(4'hA, 4'h5));
        else n_pass++;
        n_total++;
        if (a_ready_n - r0 != 1 || a_ready_at_rise !== 1'b1)
            $display("FAIL basic_ready: got %0d pulses (at cs rise %b) expected 1", a_ready_n - r0, a_ready_at_rise);
        else n_pass++;
    endtask

    task automatic test_gap();
        int f0;
        bit to;
        logic [DW-1:0] cap;
        a_capq.delete();
        f0 = a_falls;
        a_word = 4'h0;
        @(negedge clk);
        a_din = 4'hF;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (a_falls > f0 && a_cs === 1'b1) begin
                to = 1'b0;
                break;
            end
        end
        // Request a new transfer while the master is still in its gap.
        a_start = 1'b1;
        repeat (GAP_A) @(negedge clk);
        a_start = 1'b0;
        repeat (30) @(negedge clk);
        cap = (a_capq.size() > 0) ? a_capq[0] : 'x;
        n_total++;
        if (to !== 1'b0) $display("FAIL gap_timeout: cs never rose");
        else n_pass++;
        n_total++;
        if (a_dout !== exp_rx(4'hF, 4'h0)) $display("FAIL gap_dout: got %h expected %h", a_dout, exp_rx(4'hF, 4'h0));
        else n_pass++;
        n_total++;
        if (cap !== 4'hF) $display("FAIL gap_mosi: got %h expected f", cap);
        else n_pass++;
        n_total++;
        if (a_falls - f0 != 1) $display("FAIL gap_start_ignored: got %0d transfers expected 1", a_falls - f0);
        else n_pass++;
        n_total++;
        if (a_bfall_cyc - a_rise_cyc != GAP_A)
            $display("FAIL gap_busy_fall: got %0d cycles expected %0d", a_bfall_cyc - a_rise_cyc, GAP_A);
        else n_pass++;
    endtask

    task automatic test_slow();
        bit to;
        logic [DW-1:0] cap;
        b_capq.delete(); b_lowq.delete();
        xfer_b(4'h6, 4'hF, to);
        cap = (b_capq.size() > 0) ? b_capq[0] : 'x;
        n_total++;
        if (to !== 1'b0) $display("FAIL slow_timeout: busy never fell");
        else n_pass++;
        n_total++;
        if (b_hi_min != HALF_B || b_hi_max != HALF_B)
            $display("FAIL slow_sclk_high: got %0d..%0d expected %0d", b_hi_min, b_hi_max, HALF_B);
        else n_pass++;
        n_total++;
        if (b_lo_min != HALF_B || b_lo_max != HALF_B)
            $display("FAIL slow_sclk_low: got %0d..%0d expected %0d", b_lo_min, b_lo_max, HALF_B);
        else n_pass++;
        n_total++;
        if (b_lowq.size() != 1 || b_lowq[0] != int'(HALF_B * (2 * DW + 1)))
            $display("FAIL slow_cs_low: got %p expected %0d", b_lowq, HALF_B * (2 * DW + 1));
        else n_pass++;
        n_total++;
        if (b_dout !== exp_rx(4'h6, 4'hF)) $display("FAIL slow_dout: got %h expected %h", b_dout, exp_rx(4'h6, 4'hF));
        else n_pass++;
        n_total++;
        if (cap !== 4'h6) $display("FAIL slow_mosi: got %h expected 6", cap);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int f0, r0;
        bit to;
        logic [DW-1:0] d2, sw2;
        f0 = a_falls;
        a_word = DW'($urandom);
        @(negedge clk);
        a_din = DW'($urandom);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (a_falls > f0 && a_rises >= 2) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
        r0 = a_ready_n;
        #1 rst = 1'b0;
        #1;
        n_total++;
        if (to !== 1'b0) $display("FAIL rstmid_timeout: second sclk rise not seen");
        else n_pass++;
        n_total++;
        if ({a_cs, a_sclk, a_busy, a_mosi, a_ready} !== 5'b10000)
            $display("FAIL rstmid_async: got %b expected 10000", {a_cs, a_sclk, a_busy, a_mosi, a_ready});
        else n_pass++;
        repeat (2) @(negedge clk);
        n_total++;
        if (a_ready_n != r0 || a_dout !== 4'h0)
            $display("FAIL rstmid_no_ready: got %0d pulses dout %h expected 0 pulses dout 0", a_ready_n - r0, a_dout);
        else n_pass++;
        // Release reset and request a start in the same cycle.
        d2 = DW'($urandom);
        sw2 = DW'($urandom);
        a_word = sw2;
        rst = 1'b1;
        a_din = d2;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        n_total++;
        if (a_busy !== 1'b1) $display("FAIL rstmid_first_start: got busy %b expected 1", a_busy);
        else n_pass++;
        to = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (a_busy === 1'b0) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        n_total++;
        if (to !== 1'b0 || a_dout !== exp_rx(d2, sw2))
            $display("FAIL rstmid_recover: got %h expected %h (timeout %b)", a_dout, exp_rx(d2, sw2), to);
        else n_pass++;
    endtask

    task automatic test_random();
        bit to;
        logic [DW-1:0] d, sw, cap;
        for (int i = 0; i < 6; i++) begin
            d = DW'($urandom);
            sw = DW'($urandom);
            a_capq.delete(); a_lowq.delete(); a_riseq.delete();
            xfer_a(d, sw, to);
            cap = (a_capq.size() > 0) ? a_capq[0] : 'x;
            n_total++;
            if (to !== 1'b0 || a_dout !== exp_rx(d, sw))
                $display("FAIL rand_a_dout[%0d]: got %h expected %h (timeout %b)", i, a_dout, exp_rx(d, sw), to);
            else n_pass++;
            n_total++;
            if (cap !== d || a_riseq.size() != 1 || a_riseq[0] != DW || a_lowq[0] != int'(HALF_A * (2 * DW + 1)))
                $display("FAIL rand_a_bus[%0d]: got mosi %h rises %p cs_low %p expected %h %0d %0d",
                         i, cap, a_riseq, a_lowq, d, DW, HALF_A * (2 * DW + 1));
            else n_pass++;
        end
        for (int i = 0; i < 3; i++) begin
            d = DW'($urandom);
            sw = DW'($urandom);
            b_capq.delete(); b_lowq.delete(); b_riseq.delete();
            xfer_b(d, sw, to);
            cap = (b_capq.size() > 0) ? b_capq[0] : 'x;
            n_total++;
            if (to !== 1'b0 || b_dout !== exp_rx(d, sw) || cap !== d || b_lowq[0] != int'(HALF_B * (2 * DW + 1)))
                $display("FAIL rand_b[%0d]: got dout %h mosi %h cs_low %p expected %h %h %0d",
                         i, b_dout, cap, b_lowq, exp_rx(d, sw), d, HALF_B * (2 * DW + 1));
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        logic [DW-1:0] sw, c0, c1, o0, o1;
        sw = DW'($urandom);
        b_word = sw;
        b_capq.delete(); b_doutq.delete();
        @(negedge clk);
        b_din = 4'h3;
        b_start = 1'b1;
        @(negedge clk);
        // Start stays high; the next word must only be taken once the first transfer is done.
        b_din = 4'hC;
        to = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (b_busy === 1'b0) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        b_start = 1'b0;
        n_total++;
        if (to !== 1'b0 || b_busy !== 1'b1)
            $display("FAIL b2b_second_accept: got busy %b expected 1 (timeout %b)", b_busy, to);
        else n_pass++;
        for (int i = 0; i < 200; i++) begin
            if (b_busy === 1'b0) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        c0 = (b_capq.size() > 0) ? b_capq[0] : 'x;
        c1 = (b_capq.size() > 1) ? b_capq[1] : 'x;
        o0 = (b_doutq.size() > 0) ? b_doutq[0] : 'x;
        o1 = (b_doutq.size() > 1) ? b_doutq[1] : 'x;
        n_total++;
        if (b_capq.size() != 2 || c0 !== 4'h3 || c1 !== 4'hC)
            $display("FAIL b2b_mosi: got %0d words %h %h expected 3 c", b_capq.size(), c0, c1);
        else n_pass++;
        n_total++;
        if (b_doutq.size() != 2 || o0 !== exp_rx(4'h3, sw) || o1 !== exp_rx(4'hC, sw))
            $display("FAIL b2b_dout: got %0d words %h %h expected %h %h",
                     b_doutq.size(), o0, o1, exp_rx(4'h3, sw), exp_rx(4'hC, sw));
        else n_pass++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_gap();
        test_slow();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
